// File: rtl/sram_responder_if.sv
// Asynchronous-SRAM bus bundle: strobes, address and a split bidirectional data bus.
// The initiator (master) owns the strobes; the responder (slave) owns the return path.
interface sram_responder_if;
    logic        ram1EN;
    logic        ram1OE;
    logic        ram1WE;
    logic [15:0] ram1Addr;
    logic [15:0] ram1DataIn;
    logic [15:0] ram1DataOut;
    logic        ram1DataDrive;

    modport master (
        output ram1EN, ram1OE, ram1WE, ram1Addr, ram1DataIn,
        input  ram1DataOut, ram1DataDrive
    );

    modport slave (
        input  ram1EN, ram1OE, ram1WE, ram1Addr, ram1DataIn,
        output ram1DataOut, ram1DataDrive
    );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the board SRAM: samples strobes every CLK edge, stores writes
// and returns read data after a programmable number of edges.
module sram_responder #(
    parameter int DEPTH_LOG2    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int MIN_WE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    sram_responder_if.slave   bus,
    output logic              protocolErr,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        WRITE_ACTIVE
    } state_t;

    localparam logic [2:0] LAT     = 3'(READ_LATENCY);
    localparam logic [2:0] MIN_WE  = 3'(MIN_WE_CYCLES);

    state_t                  state;
    logic [15:0]             mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [15:0]             wdata;
    logic [2:0]              cnt;
    logic [2:0]              wecnt;
    logic [15:0]             data_out;
    logic                    drive;
    logic                    err;

    logic                    wr;
    logic                    rd;
    logic                    contention;
    logic                    same_addr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the same storage word.
    assign idx              = bus.ram1Addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^bus.ram1Addr;

    assign wr         = !bus.ram1EN && !bus.ram1WE;
    assign rd         = !bus.ram1EN && !bus.ram1OE && bus.ram1WE;
    assign contention = !bus.ram1EN && !bus.ram1OE && !bus.ram1WE;
    assign same_addr  = (idx == addr_q);

    assign bus.ram1DataOut   = data_out;
    assign bus.ram1DataDrive = drive;
    assign protocolErr       = err;
    assign busy              = (state != IDLE);

    // Storage is deliberately left out of the reset branch so contents survive RST.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata    <= 16'h0000;
            cnt      <= 3'd0;
            wecnt    <= 3'd0;
            data_out <= 16'h0000;
            drive    <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (contention) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (wr) begin
                        state  <= WRITE_ACTIVE;
                        addr_q <= idx;
                        wdata  <= bus.ram1DataIn;
                        wecnt  <= 3'd1;
                    end else if (rd) begin
                        addr_q <= idx;
                        cnt    <= 3'd1;
                        if (READ_LATENCY == 1) begin
                            data_out <= mem[idx];
                            drive    <= 1'b1;
                            state    <= READ_DRIVE;
                        end else begin
                            state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (wr) begin
                        state  <= WRITE_ACTIVE;
                        addr_q <= idx;
                        wdata  <= bus.ram1DataIn;
                        wecnt  <= 3'd1;
                    end else if (rd && same_addr) begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 >= LAT) begin
                            data_out <= mem[addr_q];
                            drive    <= 1'b1;
                            state    <= READ_DRIVE;
                        end
                    end else if (rd) begin
                        addr_q <= idx;
                        cnt    <= 3'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ_DRIVE: begin
                    drive <= 1'b0;
                    if (wr) begin
                        state  <= WRITE_ACTIVE;
                        addr_q <= idx;
                        wdata  <= bus.ram1DataIn;
                        wecnt  <= 3'd1;
                    end else if (rd && same_addr) begin
                        drive    <= 1'b1;
                        data_out <= mem[addr_q];
                    end else if (rd) begin
                        addr_q <= idx;
                        cnt    <= 3'd1;
                        state  <= READ_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE_ACTIVE: begin
                    if (wr) begin
                        if (!same_addr) err <= 1'b1;
                        addr_q <= idx;
                        wdata  <= bus.ram1DataIn;
                        if (wecnt != 3'd7) wecnt <= wecnt + 3'd1;
                    end else begin
                        // A WE pulse shorter than the minimum is dropped and flagged.
                        if (wecnt >= MIN_WE) mem[addr_q] <= wdata;
                        else                 err <= 1'b1;
                        if (rd) begin
                            addr_q <= idx;
                            cnt    <= 3'd1;
                            state  <= READ_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: default instance plus a MIN_WE_CYCLES=2 instance.
module tb_sram_responder;

    logic CLK = 1'b0;
    logic RST;
    logic err_a, busy_a, err_b, busy_b;
    int   checks = 0;
    int   errors = 0;

    sram_responder_if if_a ();
    sram_responder_if if_b ();

    sram_responder dut_a (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (if_a.slave),
        .protocolErr (err_a),
        .busy        (busy_a)
    );

    sram_responder #(.MIN_WE_CYCLES(2)) dut_b (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (if_b.slave),
        .protocolErr (err_b),
        .busy        (busy_b)
    );

    always #5 CLK = ~CLK;

    task automatic apply_stimulus(input bit sel_b, input logic en, input logic oe, input logic we,
                                  input logic [15:0] addr, input logic [15:0] data);
        if (sel_b) begin
            if_b.ram1EN = en; if_b.ram1OE = oe; if_b.ram1WE = we;
            if_b.ram1Addr = addr; if_b.ram1DataIn = data;
        end else begin
            if_a.ram1EN = en; if_a.ram1OE = oe; if_a.ram1WE = we;
            if_a.ram1Addr = addr; if_a.ram1DataIn = data;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000);
        apply_stimulus(1, 1, 1, 1, 16'h0000, 16'h0000);
        step(); step();
        RST = 1'b0;
        check_output("reset_drive", 16'(if_a.ram1DataDrive), 16'h0);
        check_output("reset_data",  if_a.ram1DataOut, 16'h0000);
        check_output("reset_err",   16'(err_a), 16'h0);
        check_output("reset_busy",  16'(busy_a), 16'h0);

        // Single-edge write, then read back with latency 2
        apply_stimulus(0, 0, 1, 0, 16'h0010, 16'hBEEF); step();
        check_output("wr_busy", 16'(busy_a), 16'h1);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        check_output("wr_done_busy", 16'(busy_a), 16'h0);
        apply_stimulus(0, 0, 0, 1, 16'h0010, 16'h0000); step();
        check_output("rd_wait_drive", 16'(if_a.ram1DataDrive), 16'h0);
        check_output("rd_wait_busy",  16'(busy_a), 16'h1);
        step();
        check_output("rd_drive",  16'(if_a.ram1DataDrive), 16'h1);
        check_output("rd_data",   if_a.ram1DataOut, 16'hBEEF);
        check_output("rd_err",    16'(err_a), 16'h0);
        step();
        check_output("rd_hold",   16'(if_a.ram1DataDrive), 16'h1);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        check_output("rd_release", 16'(if_a.ram1DataDrive), 16'h0);
        check_output("rd_idle",    16'(busy_a), 16'h0);

        // Address change mid-read restarts latency
        apply_stimulus(0, 0, 1, 0, 16'h0003, 16'h3333); step();
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        apply_stimulus(0, 0, 1, 0, 16'h0004, 16'h4444); step();
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        apply_stimulus(0, 0, 0, 1, 16'h0003, 16'h0000); step();
        apply_stimulus(0, 0, 0, 1, 16'h0004, 16'h0000); step();
        check_output("addrchg_nodrive", 16'(if_a.ram1DataDrive), 16'h0);
        step();
        check_output("addrchg_drive", 16'(if_a.ram1DataDrive), 16'h1);
        check_output("addrchg_data",  if_a.ram1DataOut, 16'h4444);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();

        // Long write with changing data: last value wins
        apply_stimulus(0, 0, 1, 0, 16'h0007, 16'h1111); step();
        apply_stimulus(0, 0, 1, 0, 16'h0007, 16'h2222); step();
        apply_stimulus(0, 0, 1, 0, 16'h0007, 16'h3333); step();
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        apply_stimulus(0, 0, 0, 1, 16'h0007, 16'h0000); step(); step();
        check_output("longwr_data", if_a.ram1DataOut, 16'h3333);
        check_output("longwr_err",  16'(err_a), 16'h0);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();

        // Aliased address 0x0110 reads word 0x10
        apply_stimulus(0, 0, 0, 1, 16'h0110, 16'h0000); step(); step();
        check_output("alias_data", if_a.ram1DataOut, 16'hBEEF);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();

        // OE and WE both low: write wins, no drive, error flagged
        apply_stimulus(0, 0, 0, 0, 16'h0009, 16'h00AA); step();
        check_output("cont_drive", 16'(if_a.ram1DataDrive), 16'h0);
        check_output("cont_err",   16'(err_a), 16'h1);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        check_output("cont_drive2", 16'(if_a.ram1DataDrive), 16'h0);
        apply_stimulus(0, 0, 0, 1, 16'h0009, 16'h0000); step(); step();
        check_output("cont_data",  if_a.ram1DataOut, 16'h00AA);
        check_output("cont_sticky", 16'(err_a), 16'h1);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();

        // RST during write: no commit, storage otherwise preserved
        RST = 1'b1; step(); RST = 1'b0;
        check_output("rst_err_clear", 16'(err_a), 16'h0);
        apply_stimulus(0, 0, 1, 0, 16'h0020, 16'h1234); step();
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        apply_stimulus(0, 0, 1, 0, 16'h0020, 16'h5555); step();
        RST = 1'b1;
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        RST = 1'b0;
        check_output("rstwr_busy", 16'(busy_a), 16'h0);
        apply_stimulus(0, 0, 0, 1, 16'h0020, 16'h0000); step(); step();
        check_output("rstwr_drive", 16'(if_a.ram1DataDrive), 16'h1);
        check_output("rstwr_data",  if_a.ram1DataOut, 16'h1234);

        // RST during read drive
        RST = 1'b1; step(); RST = 1'b0;
        check_output("rstrd_drive", 16'(if_a.ram1DataDrive), 16'h0);
        check_output("rstrd_busy",  16'(busy_a), 16'h0);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();
        apply_stimulus(0, 0, 0, 1, 16'h0010, 16'h0000); step(); step();
        check_output("preserve_data", if_a.ram1DataOut, 16'hBEEF);
        apply_stimulus(0, 1, 1, 1, 16'h0000, 16'h0000); step();

        // MIN_WE_CYCLES=2 instance: a one-edge write is dropped
        apply_stimulus(1, 0, 1, 0, 16'h0030, 16'h1111); step(); step();
        apply_stimulus(1, 1, 1, 1, 16'h0000, 16'h0000); step();
        check_output("b_fullwr_err", 16'(err_b), 16'h0);
        apply_stimulus(1, 0, 1, 0, 16'h0030, 16'h9999); step();
        apply_stimulus(1, 1, 1, 1, 16'h0000, 16'h0000); step();
        check_output("b_short_err", 16'(err_b), 16'h1);
        apply_stimulus(1, 0, 0, 1, 16'h0030, 16'h0000); step(); step();
        check_output("b_short_data", if_b.ram1DataOut, 16'h1111);
        apply_stimulus(1, 1, 1, 1, 16'h0000, 16'h0000); step(); step();
        check_output("b_err_sticky", 16'(err_b), 16'h1);
        RST = 1'b1; step(); RST = 1'b0;
        check_output("b_err_rst", 16'(err_b), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
